// File: rtl/sb_arb_pkg.sv
// Shared types and constants for the sideband transmit arbiter.
package sb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StGap  = 2'd2
  } sb_arb_state_e;

  localparam int unsigned SB_NUM_SRC = 3;
  localparam int unsigned SB_SRC_LT  = 0;
  localparam int unsigned SB_SRC_RSP = 1;
  localparam int unsigned SB_SRC_CMD = 2;

  function automatic logic [1:0] sb_onehot_to_idx(input logic [SB_NUM_SRC-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < SB_NUM_SRC; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sb_arb_pick.sv
// Fixed-priority frame picker (LT > rsp > cmd) with an LT anti-starvation override.
module sb_arb_pick
  import sb_arb_pkg::*;
(
  input  logic [SB_NUM_SRC-1:0] req_valid_i,
  input  logic                  lt_sat_i,
  output logic [SB_NUM_SRC-1:0] win_o,
  output logic                  lt_pick_o
);

  always_comb begin
    win_o = '0;
    // Once LT has used up its run, any waiting non-LT source goes first.
    if (lt_sat_i && (req_valid_i[SB_SRC_RSP] || req_valid_i[SB_SRC_CMD])) begin
      if (req_valid_i[SB_SRC_RSP]) win_o[SB_SRC_RSP] = 1'b1;
      else                         win_o[SB_SRC_CMD] = 1'b1;
    end else if (req_valid_i[SB_SRC_LT]) begin
      win_o[SB_SRC_LT] = 1'b1;
    end else if (req_valid_i[SB_SRC_RSP]) begin
      win_o[SB_SRC_RSP] = 1'b1;
    end else if (req_valid_i[SB_SRC_CMD]) begin
      win_o[SB_SRC_CMD] = 1'b1;
    end
  end

  assign lt_pick_o = win_o[SB_SRC_LT];

endmodule

// File: rtl/sb_tx_arbiter.sv
// Frame-granular arbiter sharing the sideband TX serializer between LT, AT rsp and AT cmd.
module sb_tx_arbiter
  import sb_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_LT_RUN = 4
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic        ser_valid,
  output logic [7:0]  ser_data,
  output logic        ser_last,
  input  logic        ser_ready,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        abort,
  output logic [1:0]  abort_id
);

  localparam int unsigned StallW = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned RunW   = (MAX_LT_RUN > 0) ? $clog2(MAX_LT_RUN + 1) : 1;

  sb_arb_state_e         state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [RunW-1:0]       lt_run_q, lt_run_d;
  logic [StallW-1:0]     stall_q, stall_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [1:0]            abort_id_q, abort_id_d;

  logic [1:0] g_idx;
  logic       src_valid, src_last;
  logic [7:0] src_data;
  logic       timeout_hit, xfer_fire, frame_end, gap_last, can_pick, lt_sat;
  logic [2:0] win;
  logic       lt_pick;

  assign g_idx     = sb_onehot_to_idx(grant_q);
  assign src_valid = req_valid[g_idx];
  assign src_last  = req_last[g_idx];
  assign src_data  = req_data[{g_idx, 3'b000} +: 8];

  assign timeout_hit = (state_q == StXfer) && (stall_q == StallW'(TIMEOUT));
  assign xfer_fire   = (state_q == StXfer) && !timeout_hit && src_valid && ser_ready;
  assign frame_end   = xfer_fire && src_last;
  assign gap_last    = (state_q == StGap) && (gap_q == GapW'(GAP_CYCLES - 1));
  assign lt_sat      = (lt_run_q == RunW'(MAX_LT_RUN));

  // The final gap cycle arbitrates so the next grant lands right after the gap.
  assign can_pick = enable && (|req_valid) &&
                    ((state_q == StIdle) || gap_last || (frame_end && (GAP_CYCLES == 0)));

  sb_arb_pick u_pick (
    .req_valid_i (req_valid),
    .lt_sat_i    (lt_sat),
    .win_o       (win),
    .lt_pick_o   (lt_pick)
  );

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      lt_run_q   <= '0;
      stall_q    <= '0;
      gap_q      <= '0;
      abort_id_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      lt_run_q   <= lt_run_d;
      stall_q    <= stall_d;
      gap_q      <= gap_d;
      abort_id_q <= abort_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    lt_run_d   = lt_run_q;
    stall_d    = stall_q;
    gap_d      = gap_q;
    abort_id_d = abort_id_q;
    case (state_q)
      StIdle: ;
      StXfer: begin
        if (timeout_hit || frame_end) begin
          if (timeout_hit) abort_id_d = g_idx;
          grant_d = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (xfer_fire) begin
          stall_d = '0;
        end else if (!src_valid) begin
          stall_d = stall_q + 1'b1;
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (can_pick) begin
      state_d = StXfer;
      grant_d = win;
      stall_d = '0;
      if (lt_pick && (req_valid[SB_SRC_RSP] || req_valid[SB_SRC_CMD])) begin
        lt_run_d = lt_sat ? lt_run_q : lt_run_q + 1'b1;
      end else begin
        lt_run_d = '0;
      end
    end
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_data  = '0;
    ser_last  = 1'b0;
    req_ready = '0;
    if ((state_q == StXfer) && !timeout_hit) begin
      ser_valid        = src_valid;
      ser_data         = src_data;
      ser_last         = src_last;
      req_ready[g_idx] = ser_ready;
    end
    grant    = grant_q;
    busy     = (state_q != StIdle);
    abort    = timeout_hit;
    abort_id = timeout_hit ? g_idx : abort_id_q;
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed scoreboard bench for sb_tx_arbiter: source models feed frames, a monitor checks bytes.
module tb_sb_tx_arbiter;
  import sb_arb_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        enable = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic [2:0]  req_ready;
  logic        ser_valid;
  logic [7:0]  ser_data;
  logic        ser_last;
  logic        ser_ready = 1'b1;
  logic [2:0]  grant;
  logic        busy;
  logic        abort;
  logic [1:0]  abort_id;

  logic        enable_nxt = 1'b1;
  logic        ser_ready_nxt = 1'b1;
  logic [8:0]  src_q [3][$];
  logic [2:0]  hold = '0;
  int          hold_after [3] = '{0, 0, 0};
  exp_t        exp_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int xfer_cnt = 0;
  int last_cnt = 0;
  int abort_cnt = 0;
  int last_xfer_cyc = 0;

  sb_tx_arbiter dut (
    .sb_clk    (sb_clk),
    .rst       (rst),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_last  (ser_last),
    .ser_ready (ser_ready),
    .grant     (grant),
    .busy      (busy),
    .abort     (abort),
    .abort_id  (abort_id)
  );

  always #5 sb_clk = ~sb_clk;
  always @(posedge sb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge sb_clk);
    #3;
  endtask

  task automatic src_frame(input int s, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) src_q[s].push_back({(j == n - 1), base + 8'(j)});
  endtask

  task automatic exp_frame(input int s, input logic [7:0] base, input int n, input int c);
    for (int j = 0; j < n; j++)
      exp_q.push_back('{src: s, data: base + 8'(j), last: (j == n - 1), cyc: (c < 0) ? -1 : c + j});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_done"}, int'(exp_q.size() == 0 && !busy), 1);
  endtask

  // Source models and serializer-ready driver: drive on negedge, retire handshakes just after.
  initial begin : driver
    forever begin
      @(negedge sb_clk);
      enable    = enable_nxt;
      ser_ready = ser_ready_nxt;
      for (int i = 0; i < 3; i++) begin
        if (src_q[i].size() > 0 && !hold[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          void'(src_q[i].pop_front());
          if (hold_after[i] > 0) begin
            hold_after[i]--;
            if (hold_after[i] == 0) hold[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sb_clk);
      #2;
      if (abort) abort_cnt++;
      if (ser_valid && ser_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (ser_last) last_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got data 0x%0h grant %0b, expected no transfer",
                   ser_data, grant);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data", int'(ser_data), int'(e.data));
          check("xfer_last", int'(ser_last), int'(e.last));
          check("xfer_grant", int'(grant), 1 << e.src);
          if (e.cyc >= 0) check("xfer_cycle", cyc - c0, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int n, k, d, base_x, base_a, base_l;
    bit seen;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Three simultaneous 3-byte frames, loaded while reset is held.
    src_frame(0, 8'h10, 3);
    src_frame(1, 8'h20, 3);
    src_frame(2, 8'h30, 3);
    exp_frame(0, 8'h10, 3, 1);
    exp_frame(1, 8'h20, 3, 6);
    exp_frame(2, 8'h30, 3, 11);
    step();
    step();
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_abort", int'(abort), 0);
    check("rst_abort_id", int'(abort_id), 0);
    check("rst_ser_valid", int'(ser_valid), 0);
    check("rst_ser_last", int'(ser_last), 0);
    check("rst_ser_data", int'(ser_data), 0);
    check("rst_req_ready", int'(req_ready), 0);
    rst = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 6; j++) begin
      step();
      k = cyc - c0;
      if (k == 1) check("t1_grant_latency", int'(grant), 3'b001);
      if (k == 4) begin
        check("t1_gap_grant", int'(grant), 0);
        check("t1_gap_busy", int'(busy), 1);
        check("t1_gap_ser_valid", int'(ser_valid), 0);
      end
      if (k == 5) check("t1_gap_req_ready", int'(req_ready), 0);
    end
    wait_done("t1", 100);

    // LT floods single-byte frames while cmd waits; cmd gets in after MAX_LT_RUN LT grants.
    for (int j = 0; j < 6; j++) src_frame(0, 8'h40 + 8'(j), 1);
    src_frame(2, 8'h50, 2);
    for (int j = 0; j < 4; j++) exp_frame(0, 8'h40 + 8'(j), 1, -1);
    exp_frame(2, 8'h50, 2, -1);
    exp_frame(0, 8'h44, 1, -1);
    exp_frame(0, 8'h45, 1, -1);
    wait_done("t2", 200);
    check("t2_lt_run_zero", int'(dut.lt_run_q), 0);

    // Rsp source stalls after its first byte: expect an abort and no last byte.
    base_l = last_cnt;
    hold_after[1] = 1;
    src_frame(1, 8'h60, 4);
    exp_frame(1, 8'h60, 1, -1);
    exp_q[exp_q.size() - 1].last = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      step();
      n++;
      if (abort) seen = 1'b1;
    end
    check("t3_abort_seen", int'(seen), 1);
    d = cyc - last_xfer_cyc;
    check("t3_abort_latency", int'(d == TMO || d == TMO + 1), 1);
    check("t3_abort_id", int'(abort_id), 1);
    check("t3_abort_ser_valid", int'(ser_valid), 0);
    step();
    check("t3_abort_pulse", int'(abort), 0);
    check("t3_gap_grant", int'(grant), 0);
    check("t3_gap_busy", int'(busy), 1);
    check("t3_abort_id_hold", int'(abort_id), 1);
    check("t3_no_last", last_cnt - base_l, 0);
    src_q[1].delete();
    hold[1] = 1'b0;
    hold_after[1] = 0;
    wait_done("t3", 50);

    // Serializer backpressure for 40 cycles mid-frame must not abort.
    base_a = abort_cnt;
    base_x = xfer_cnt;
    src_frame(0, 8'h70, 4);
    exp_frame(0, 8'h70, 4, -1);
    n = 0;
    while (xfer_cnt == base_x && n < 20) begin
      step();
      n++;
    end
    ser_ready_nxt = 1'b0;
    step();
    base_x = xfer_cnt;
    for (int j = 0; j < 40; j++) step();
    check("t4_no_xfer_while_stalled", xfer_cnt - base_x, 0);
    check("t4_grant_held", int'(grant), 3'b001);
    check("t4_src_valid", int'(ser_valid), 1);
    ser_ready_nxt = 1'b1;
    wait_done("t4", 50);
    check("t4_no_abort", abort_cnt - base_a, 0);

    // Dropping enable mid-frame finishes the frame and blocks the next grant.
    src_frame(2, 8'h80, 4);
    exp_frame(2, 8'h80, 4, -1);
    n = 0;
    while (grant != 3'b100 && n < 20) begin
      step();
      n++;
    end
    enable_nxt = 1'b0;
    src_frame(0, 8'h90, 1);
    exp_frame(0, 8'h90, 1, -1);
    for (int j = 0; j < 20; j++) step();
    check("t5_pending_only_lt", exp_q.size(), 1);
    check("t5_idle_grant", int'(grant), 0);
    check("t5_idle_busy", int'(busy), 0);
    check("t5_idle_req_ready", int'(req_ready), 0);
    enable_nxt = 1'b1;
    wait_done("t5", 50);

    // Reset mid-frame drops the frame; a retransmitted LT frame is granted one cycle after release.
    base_x = xfer_cnt;
    src_frame(0, 8'hA0, 4);
    exp_frame(0, 8'hA0, 2, -1);
    exp_q[exp_q.size() - 1].last = 1'b0;
    n = 0;
    while (xfer_cnt - base_x < 2 && n < 20) begin
      step();
      n++;
    end
    rst = 1'b0;
    #1;
    check("t6_rst_ser_valid", int'(ser_valid), 0);
    check("t6_rst_req_ready", int'(req_ready), 0);
    check("t6_rst_grant", int'(grant), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_ser_data", int'(ser_data), 0);
    src_q[0].delete();
    src_frame(0, 8'hB0, 2);
    exp_frame(0, 8'hB0, 2, 1);
    step();
    step();
    rst = 1'b1;
    c0 = cyc;
    step();
    check("t6_regrant_latency", int'(grant), 3'b001);
    wait_done("t6", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
